// File: rtl/decrypt_word_packer_if.sv
// Byte-in / word-out bus of the decrypt word packer.
// master drives the byte stream and consumer ready; slave is the packer.
interface decrypt_word_packer_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic          v;
    logic [7:0]    din;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;
    logic [3:0]    out_be;
    logic          out_last;
    logic [LW-1:0] level;
    logic          overflow;

    modport master (
        output v, din, flush, out_ready,
        input  out_valid, out_data, out_be, out_last, level, overflow
    );

    modport slave (
        input  v, din, flush, out_ready,
        output out_valid, out_data, out_be, out_last, level, overflow
    );
endinterface

// File: rtl/decrypt_word_packer.sv
// Packs the decrypt pipeline byte stream into 32-bit little-endian words and
// buffers them in a small FIFO with a sticky overflow flag.
module decrypt_word_packer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    decrypt_word_packer_if.slave  bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  be;
        logic        last;
    } word_t;

    logic [31:0]   acc_q, acc_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [31:0]   merged;
    logic [2:0]    n_bytes;
    logic          push;
    word_t         push_word;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          overflow_q, overflow_d;
    logic          empty, full, pop, wr_en;
    word_t         mem [DEPTH];
    word_t         head;

    // Packer: merge the incoming byte, decide whether this cycle closes a word.
    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        push      = 1'b0;
        push_word = '0;
        merged    = acc_q;
        n_bytes   = {1'b0, cnt_q} + 3'(bus.v);
        if (bus.v) begin
            merged[{cnt_q, 3'b000} +: 8] = bus.din;
        end
        if ((bus.v && (cnt_q == 2'd3)) || (bus.flush && (n_bytes != 3'd0))) begin
            push           = 1'b1;
            push_word.data = merged;
            push_word.be   = 4'((5'd1 << n_bytes) - 5'd1);
            push_word.last = bus.flush;
            acc_d          = '0;
            cnt_d          = '0;
        end else if (bus.v) begin
            acc_d = merged;
            cnt_d = cnt_q + 2'd1;
        end
    end

    // FIFO control: a push into a full FIFO survives only if a pop frees a slot.
    always_comb begin
        empty      = (level_q == '0);
        full       = (level_q == LW'(DEPTH));
        pop        = !empty && bus.out_ready;
        wr_en      = push && (!full || pop);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q | (push && full && !pop);
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({wr_en, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: reads are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem[wr_ptr_q] <= push_word;
        end
    end

    assign head          = mem[rd_ptr_q];
    assign bus.out_valid = !empty;
    assign bus.out_data  = empty ? 32'h0 : head.data;
    assign bus.out_be    = empty ? 4'h0  : head.be;
    assign bus.out_last  = empty ? 1'b0  : head.last;
    assign bus.level     = level_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_decrypt_word_packer.sv
// Scoreboard bench for decrypt_word_packer: expected words are queued as bytes
// are driven and compared by a monitor whenever the consumer accepts a word.
module tb_decrypt_word_packer;
    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  be;
        logic        last;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   passed;
    exp_t exp_q[$];
    exp_t mon_e;

    decrypt_word_packer_if #(.DEPTH(DEPTH)) bus ();

    decrypt_word_packer #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every accepted word must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_word: got data=%h be=%b last=%b, required no word",
                         bus.out_data, bus.out_be, bus.out_last);
            end else begin
                mon_e = exp_q.pop_front();
                if ({bus.out_data, bus.out_be, bus.out_last} !== mon_e) begin
                    $display("FAIL word: got data=%h be=%b last=%b, required data=%h be=%b last=%b",
                             bus.out_data, bus.out_be, bus.out_last,
                             mon_e.data, mon_e.be, mon_e.last);
                end else begin
                    passed++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic fl);
        bus.v     = 1'b1;
        bus.din   = b;
        bus.flush = fl;
        step();
        bus.v     = 1'b0;
        bus.din   = 8'h0;
        bus.flush = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic fl);
        for (int i = 0; i < 4; i++) begin
            send(w[8*i +: 8], fl && (i == 3));
        end
        exp_q.push_back({w, 4'hF, fl});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic drain();
        int n;
        bus.out_ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || bus.out_valid)
            $display("FAIL drain: got %0d expected words left, out_valid=%b, required 0/0",
                     exp_q.size(), bus.out_valid);
        else
            passed++;
    endtask

    task automatic check_idle_outputs(input string tag);
        checks++;
        if ({bus.out_valid, bus.out_data, bus.out_be, bus.out_last, bus.level, bus.overflow} !== '0)
            $display("FAIL %s: got valid=%b data=%h be=%b last=%b level=%0d ovf=%b, required all 0",
                     tag, bus.out_valid, bus.out_data, bus.out_be, bus.out_last,
                     bus.level, bus.overflow);
        else
            passed++;
    endtask

    task automatic test_reset();
        bus.v = 1'b0; bus.din = 8'h0; bus.flush = 1'b0; bus.out_ready = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check_idle_outputs("reset_state");
    endtask

    task automatic test_word_assembly();
        bus.out_ready = 1'b1;
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL asm_early: got out_valid=%b, required 0", bus.out_valid);
        else passed++;
        send(8'h44, 1'b0);
        exp_q.push_back({32'h44332211, 4'hF, 1'b0});
        checks++;
        if (bus.out_valid !== 1'b1 || bus.level !== 3'd1)
            $display("FAIL asm_latency: got valid=%b level=%0d, required 1/1", bus.out_valid, bus.level);
        else passed++;
        step();
        checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL asm_one_cycle: got out_valid=%b, required 0", bus.out_valid);
        else passed++;
        drain();
    endtask

    task automatic test_partial_flush();
        bus.out_ready = 1'b1;
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        exp_q.push_back({32'h0000BBAA, 4'b0011, 1'b1});
        step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        step();
        checks++;
        if (bus.level !== 3'd0 || bus.out_valid !== 1'b0)
            $display("FAIL empty_flush: got level=%0d valid=%b, required 0/0", bus.level, bus.out_valid);
        else passed++;
        drain();
    endtask

    task automatic test_flush_coincident();
        bus.out_ready = 1'b1;
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b1);
        exp_q.push_back({32'h00030201, 4'b0111, 1'b1});
        send_word(32'hA4A3A2A1, 1'b1);
        send(8'h5A, 1'b1);
        exp_q.push_back({32'h0000005A, 4'b0001, 1'b1});
        drain();
    endtask

    task automatic test_overflow();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            send(8'(i), 1'b0);
            if (i == 15) begin
                checks++;
                if (bus.level !== 3'd4 || bus.overflow !== 1'b0)
                    $display("FAIL ovf_at_full: got level=%0d ovf=%b, required 4/0", bus.level, bus.overflow);
                else passed++;
            end
        end
        for (int k = 0; k < 4; k++)
            exp_q.push_back({8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k), 4'hF, 1'b0});
        checks++;
        if (bus.level !== 3'd4 || bus.overflow !== 1'b1)
            $display("FAIL ovf_set: got level=%0d ovf=%b, required 4/1", bus.level, bus.overflow);
        else passed++;
        step();
        checks++;
        if (bus.out_data !== 32'h03020100 || bus.out_valid !== 1'b1)
            $display("FAIL ovf_head_stable: got data=%h valid=%b, required 03020100/1", bus.out_data, bus.out_valid);
        else passed++;
        drain();
        checks++;
        if (bus.overflow !== 1'b1) $display("FAIL ovf_sticky: got ovf=%b, required 1", bus.overflow);
        else passed++;
        do_reset();
        check_idle_outputs("ovf_cleared_by_reset");
    endtask

    task automatic test_full_push_pop();
        logic [31:0] w4;
        w4 = 32'hC0FFEE42;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 4; k++)
            send_word($urandom, 1'b0);
        send(w4[7:0], 1'b0);
        send(w4[15:8], 1'b0);
        send(w4[23:16], 1'b0);
        checks++;
        if (bus.level !== 3'd4) $display("FAIL pp_full: got level=%0d, required 4", bus.level);
        else passed++;
        bus.out_ready = 1'b1;
        send(w4[31:24], 1'b0);
        exp_q.push_back({w4, 4'hF, 1'b0});
        bus.out_ready = 1'b0;
        checks++;
        if (bus.level !== 3'd4 || bus.overflow !== 1'b0)
            $display("FAIL pp_level: got level=%0d ovf=%b, required 4/0", bus.level, bus.overflow);
        else passed++;
        drain();
    endtask

    task automatic test_back_to_back();
        logic [2:0] max_level;
        max_level = '0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            logic [31:0] w;
            w = $urandom;
            for (int i = 0; i < 4; i++) begin
                send(w[8*i +: 8], 1'b0);
                if (bus.level > max_level) max_level = bus.level;
            end
            exp_q.push_back({w, 4'hF, 1'b0});
        end
        checks++;
        if (max_level !== 3'd1) $display("FAIL b2b_level: got max level=%0d, required 1", max_level);
        else passed++;
        drain();
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        send_word(32'h12345678, 1'b0);
        send_word(32'h9ABCDEF0, 1'b0);
        send(8'hE1, 1'b0);
        send(8'hE2, 1'b0);
        rst = 1'b1;
        bus.v = 1'b1; bus.din = 8'hEE; bus.flush = 1'b1;
        step();
        rst = 1'b0;
        bus.v = 1'b0; bus.din = 8'h0; bus.flush = 1'b0;
        exp_q.delete();
        check_idle_outputs("reset_mid");
        bus.out_ready = 1'b1;
        send_word(32'h88776655, 1'b0);
        drain();
    endtask

    initial begin
        checks = 0;
        passed = 0;
        rst = 1'b0;
        test_reset();
        test_word_assembly();
        test_partial_flush();
        test_flush_coincident();
        test_overflow();
        test_full_push_pop();
        test_back_to_back();
        test_reset_mid();
        step();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
